// File: rtl/bus_mux_rr.sv
// bus_mux_rr: registered N-way source multiplexer with valid/ready handshake.
// A channel is chosen either by an explicit select code or by round-robin
// search after the last granted channel. The winning word is captured into a
// single output register that honours downstream back-pressure.

// Per-channel ready decode: a channel is acknowledged only when it is the
// accepted candidate.
module bus_mux_rr_lane #(
   parameter int SELW = 3,
   parameter int IDX  = 0
) (
   input  logic            accept_i,
   input  logic [SELW-1:0] cand_idx_i,
   output logic            ready_o
);
   localparam logic [SELW-1:0] MY_CODE = SELW'(IDX);

   // Single-hot acknowledge for this channel
   always_comb begin
      ready_o = accept_i && (cand_idx_i == MY_CODE);
   end
endmodule

module bus_mux_rr #(
   parameter int WIDTH = 8,
   parameter int N     = 5,
   parameter int SELW  = 3
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [N*WIDTH-1:0] in_data_i,
   input  logic [N-1:0]       in_valid_i,
   output logic [N-1:0]       in_ready_o,
   input  logic [SELW-1:0]    sel_i,
   input  logic               mode_i,
   output logic [WIDTH-1:0]   out_data_o,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [SELW-1:0]    out_grant_o,
   output logic               sel_err_o
);
   // Every select code has a slot here; codes >= N see a permanently idle
   // channel, so the direct-mode lookup never indexes past in_valid_i.
   localparam int              SPAN    = 2**SELW;
   localparam logic [SELW:0]   N_CODE  = (SELW+1)'(N);
   localparam logic [SELW-1:0] PTR_RST = SELW'(N-1);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic [SELW-1:0]  grant_q, grant_d;
   logic [SELW-1:0]  ptr_q, ptr_d;
   logic             sel_err_q, sel_err_d;

   logic [SPAN-1:0]  vld_ext;
   logic             sel_ok;
   logic             dir_vld;
   logic             rr_found;
   logic [SELW-1:0]  rr_idx;
   int               rr_pos;
   logic             cand_vld;
   logic [SELW-1:0]  cand_idx;
   logic [WIDTH-1:0] cand_data;
   logic             load_ok;
   logic             accept;

   assign vld_ext = SPAN'(in_valid_i);
   assign sel_ok  = ({1'b0, sel_i} < N_CODE);
   assign dir_vld = sel_ok && vld_ext[sel_i];

   // Round-robin search: first valid channel strictly after ptr, wrapping
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      rr_pos   = 0;
      for (int k = 1; k <= N; k++) begin
         rr_pos = int'(ptr_q) + k;
         if (rr_pos >= N) rr_pos = rr_pos - N;
         if (!rr_found && in_valid_i[rr_pos]) begin
            rr_found = 1'b1;
            rr_idx   = SELW'(rr_pos);
         end
      end
   end

   // Candidate choice and accept decision; reset blocks any handshake
   always_comb begin
      cand_idx = mode_i ? rr_idx : sel_i;
      cand_vld = mode_i ? rr_found : dir_vld;
      load_ok  = !valid_q || out_ready_i;
      accept   = load_ok && cand_vld && !rst_i;
   end

   // Data mux is only needed on the register input, never toward in_ready
   always_comb begin
      cand_data = '0;
      for (int i = 0; i < N; i++) begin
         if (cand_idx == SELW'(i)) cand_data = in_data_i[i*WIDTH +: WIDTH];
      end
   end

   genvar g;
   generate
      for (g = 0; g < N; g++) begin : g_lane
         bus_mux_rr_lane #(.SELW(SELW), .IDX(g)) u_lane (
            .accept_i   (accept),
            .cand_idx_i (cand_idx),
            .ready_o    (in_ready_o[g])
         );
      end
   endgenerate

   // Next-state: load on accept, drain when consumed without refill, else hold
   always_comb begin
      data_d    = data_q;
      valid_d   = valid_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      sel_err_d = !mode_i && !sel_ok && load_ok;
      if (accept) begin
         data_d  = cand_data;
         grant_d = cand_idx;
         valid_d = 1'b1;
         ptr_d   = cand_idx;
      end else if (out_ready_i) begin
         valid_d = 1'b0;
      end
   end

   // State registers; ptr resets to N-1 so the first search begins at 0
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q    <= '0;
         valid_q   <= 1'b0;
         grant_q   <= '0;
         ptr_q     <= PTR_RST;
         sel_err_q <= 1'b0;
      end else begin
         data_q    <= data_d;
         valid_q   <= valid_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
         sel_err_q <= sel_err_d;
      end
   end

   assign out_data_o  = data_q;
   assign out_valid_o = valid_q;
   assign out_grant_o = grant_q;
   assign sel_err_o   = sel_err_q;
endmodule

// File: tb/tb_bus_mux_rr.sv
// Directed bench for bus_mux_rr: default N=5 instance plus an N=2 instance.
module tb_bus_mux_rr;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Instance A: WIDTH=8, N=5, SELW=3
   logic        rst_a;
   logic [39:0] din_a;
   logic [4:0]  vld_a, rdy_a;
   logic [2:0]  sel_a, gnt_a;
   logic        mode_a, ov_a, ordy_a, err_a;
   logic [7:0]  dout_a;

   bus_mux_rr #(.WIDTH(8), .N(5), .SELW(3)) u_a (
      .clk_i(clk), .rst_i(rst_a), .in_data_i(din_a), .in_valid_i(vld_a),
      .in_ready_o(rdy_a), .sel_i(sel_a), .mode_i(mode_a), .out_data_o(dout_a),
      .out_valid_o(ov_a), .out_ready_i(ordy_a), .out_grant_o(gnt_a),
      .sel_err_o(err_a)
   );

   // Instance B: WIDTH=16, N=2, SELW=1
   logic        rst_b;
   logic [31:0] din_b;
   logic [1:0]  vld_b, rdy_b;
   logic        sel_b, gnt_b;
   logic        mode_b, ov_b, ordy_b, err_b;
   logic [15:0] dout_b;

   bus_mux_rr #(.WIDTH(16), .N(2), .SELW(1)) u_b (
      .clk_i(clk), .rst_i(rst_b), .in_data_i(din_b), .in_valid_i(vld_b),
      .in_ready_o(rdy_b), .sel_i(sel_b), .mode_i(mode_b), .out_data_o(dout_b),
      .out_valid_o(ov_b), .out_ready_i(ordy_b), .out_grant_o(gnt_b),
      .sel_err_o(err_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0]  va [5];
   logic [15:0] vb [2];
   int          rr_seq [5];

   initial begin
      va[0] = 8'd0; va[1] = 8'd31; va[2] = 8'd63; va[3] = 8'd127; va[4] = 8'd255;
      vb[0] = 16'h1234; vb[1] = 16'hBEEF;
      din_a = {va[4], va[3], va[2], va[1], va[0]};
      din_b = {vb[1], vb[0]};
      rr_seq[0] = 0; rr_seq[1] = 2; rr_seq[2] = 4; rr_seq[3] = 0; rr_seq[4] = 2;

      rst_a = 1'b1; vld_a = 5'b11111; sel_a = 3'd0; mode_a = 1'b0; ordy_a = 1'b1;
      rst_b = 1'b1; vld_b = 2'b00; sel_b = 1'b0; mode_b = 1'b0; ordy_b = 1'b1;

      // ---- reset state; handshake suppressed while rst is high
      #1;
      chk("rst_in_ready", 32'(rdy_a), 32'h0);
      tick(); tick();
      chk("rst_out_valid", 32'(ov_a), 32'h0);
      chk("rst_out_data", 32'(dout_a), 32'h0);
      chk("rst_out_grant", 32'(gnt_a), 32'h0);
      chk("rst_sel_err", 32'(err_a), 32'h0);

      // ---- direct sweep sel 0..4
      rst_a = 1'b0;
      for (int i = 0; i < 5; i++) begin
         sel_a = 3'(i);
         #1;
         chk($sformatf("dir_in_ready_%0d", i), 32'(rdy_a), 32'(5'b1 << i));
         tick();
         chk($sformatf("dir_data_%0d", i), 32'(dout_a), 32'(va[i]));
         chk($sformatf("dir_grant_%0d", i), 32'(gnt_a), 32'(i));
         chk($sformatf("dir_valid_%0d", i), 32'(ov_a), 32'h1);
         chk($sformatf("dir_err_%0d", i), 32'(err_a), 32'h0);
      end

      // ---- bad select codes 5,6,7
      for (int i = 5; i < 8; i++) begin
         sel_a = 3'(i);
         #1;
         chk($sformatf("bad_in_ready_%0d", i), 32'(rdy_a), 32'h0);
         tick();
         chk($sformatf("bad_sel_err_%0d", i), 32'(err_a), 32'h1);
         chk($sformatf("bad_valid_%0d", i), 32'(ov_a), 32'h0);
         chk($sformatf("bad_data_hold_%0d", i), 32'(dout_a), 32'd255);
      end
      sel_a = 3'd0; vld_a = 5'b00000;
      tick();
      chk("bad_err_clear", 32'(err_a), 32'h0);
      chk("bad_idle_valid", 32'(ov_a), 32'h0);

      // ---- round-robin from reset, sparse valid; sel ignored
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0; mode_a = 1'b1; vld_a = 5'b10101; sel_a = 3'd7;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("rr_in_ready_%0d", i), 32'(rdy_a), 32'(5'b1 << rr_seq[i]));
         tick();
         chk($sformatf("rr_grant_%0d", i), 32'(gnt_a), 32'(rr_seq[i]));
         chk($sformatf("rr_data_%0d", i), 32'(dout_a), 32'(va[rr_seq[i]]));
         chk($sformatf("rr_err_%0d", i), 32'(err_a), 32'h0);
      end
      vld_a = 5'b00010;
      tick();
      chk("rr_single_grant", 32'(gnt_a), 32'd1);
      chk("rr_single_data", 32'(dout_a), 32'd31);

      // ---- back-pressure: hold word from channel 1 for 3 cycles
      vld_a = 5'b11111; ordy_a = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("bp_in_ready_%0d", i), 32'(rdy_a), 32'h0);
         tick();
         chk($sformatf("bp_data_%0d", i), 32'(dout_a), 32'd31);
         chk($sformatf("bp_grant_%0d", i), 32'(gnt_a), 32'd1);
         chk($sformatf("bp_valid_%0d", i), 32'(ov_a), 32'h1);
      end
      ordy_a = 1'b1;
      #1;
      chk("bp_release_ready", 32'(rdy_a), 32'b00100);
      tick();
      chk("bp_nobubble_valid", 32'(ov_a), 32'h1);
      chk("bp_nobubble_grant", 32'(gnt_a), 32'd2);
      chk("bp_nobubble_data", 32'(dout_a), 32'd63);

      // ---- reset while a word is pending and stalled
      ordy_a = 1'b0; rst_a = 1'b1;
      #1;
      chk("rmid_in_ready", 32'(rdy_a), 32'h0);
      tick();
      chk("rmid_valid", 32'(ov_a), 32'h0);
      chk("rmid_data", 32'(dout_a), 32'h0);
      rst_a = 1'b0; ordy_a = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("rmid_fair_grant_%0d", i), 32'(gnt_a), 32'(i % 5));
         chk($sformatf("rmid_fair_data_%0d", i), 32'(dout_a), 32'(va[i % 5]));
      end

      // ---- N=2, SELW=1, WIDTH=16 instance
      vld_b = 2'b11; mode_b = 1'b1;
      #1;
      chk("b_rst_ready", 32'(rdy_b), 32'h0);
      tick();
      chk("b_rst_valid", 32'(ov_b), 32'h0);
      rst_b = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sel_b = 1'(i);
         tick();
         chk($sformatf("b_grant_%0d", i), 32'(gnt_b), 32'(i % 2));
         chk($sformatf("b_data_%0d", i), 32'(dout_b), 32'(vb[i % 2]));
         chk($sformatf("b_err_%0d", i), 32'(err_b), 32'h0);
      end
      mode_b = 1'b0; sel_b = 1'b0;
      tick();
      chk("b_dir_grant", 32'(gnt_b), 32'd0);
      chk("b_dir_data", 32'(dout_b), 32'h1234);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/bus_mux_rr.md
# bus_mux_rr

Parametrised registered N-way datapath multiplexer with valid/ready handshaking, replacing fixed-width combinational source selection on the RISC_SPM internal bus. It selects one of N source channels by an explicit select code or by round-robin arbitration, captures the chosen word in an output register, and presents it downstream, for example to the ALU operand or memory-write path. The block enforces one-cycle latency and back-pressure, and flags out-of-range select codes.

## Interface
- WIDTH, 8, data width of each channel
- N, 5, number of source channels (2..16)
- SELW, 3, select/grant code width; must satisfy 2**SELW >= N
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_data  input  N*WIDTH  flattened sources; channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N  channel i has a word
- in_ready  output  N  channel i word accepted this cycle (combinational)
- sel  input  SELW  channel code, used when mode=0
- mode  input  1  0 = direct select, 1 = round-robin
- out_data  output  WIDTH  registered selected word
- out_valid  output  1  out_data holds an unconsumed word
- out_ready  input  1  downstream consumes out_data this cycle
- out_grant  output  SELW  channel index that out_data came from
- sel_err  output  1  one-cycle pulse: direct select code >= N while loading was possible

## Operation
- load_ok = !out_valid || out_ready; output register accepts a new word only when load_ok.
- Direct mode (mode=0):
  - Candidate is sel when sel < N.
  - Accept when load_ok && in_valid[sel].
  - If sel >= N: no accept, all in_ready=0, sel_err=1 next cycle if load_ok.
- Round-robin mode (mode=1):
  - Search starts at (ptr+1) mod N and wraps; the first channel with in_valid set is the candidate.
  - Accept when load_ok and a candidate exists. sel is ignored and sel_err stays 0.
- in_ready[i] = 1 only for the accepted channel; at most one bit is set. in_ready may depend on in_valid.
- On accept:
  - out_data <= in_data of the candidate channel.
  - out_grant <= candidate index.
  - out_valid <= 1.
  - ptr <= candidate index, in both modes.
- If out_ready && !accept: out_valid <= 0; out_data and out_grant hold their last value.
- If out_valid && !out_ready: out_data, out_grant, out_valid and ptr all hold (stall).
- A mode change takes effect on the same cycle's decision. ptr is preserved across mode changes.

## Timing
- Reset values (synchronous reset, dominates all other inputs):
  - out_data=0, out_valid=0, out_grant=0, sel_err=0.
  - ptr=N-1, so the first round-robin search starts at channel 0.
- Latency: a word accepted at edge k appears on out_data/out_valid after edge k.
- Throughput: 1 word/cycle when out_ready is held high.
- Simultaneous consume and accept: the old word leaves and the new word loads on the same edge, with no bubble.
- Reset mid-transfer: a pending out_valid word is discarded, and in_ready is 0 during the reset cycle.
- Round-robin fairness: with all N channels valid continuously, each channel is granted exactly once per N accepts, in index order.
- in_ready is combinational from in_valid, sel, mode, out_valid, out_ready and ptr. There is no combinational path from in_data.

## Test plan
- Direct sweep, N=5, WIDTH=8:
  - Stimulus: in0..in4 = 0, 31, 63, 127, 255; all in_valid=1; out_ready=1; sel steps 0→4, one per cycle.
  - Required: out_data follows 0, 31, 63, 127, 255 one cycle late, with out_grant equal to the previous cycle's sel.
- Bad select:
  - Stimulus: sel=5, 6, 7 with out_ready=1.
  - Required: in_ready=0, sel_err pulses each following cycle, out_valid drops to 0 after the last word drains.
- Round-robin:
  - Stimulus: mode=1; in_valid=5'b10101 held; out_ready=1 from reset.
  - Required: grants 0, 2, 4, 0, 2…
  - Stimulus: then in_valid=5'b00010.
  - Required: grant 1 next.
- Back-pressure:
  - Stimulus: out_ready=0 for 3 cycles after the first load.
  - Required: out_data, out_grant and ptr frozen; in_ready all 0.
  - Stimulus: out_ready=1.
  - Required: the next word loads on the same edge, with no bubble.
- Reset mid-operation:
  - Stimulus: assert rst while out_valid=1 and out_ready=0.
  - Required: next cycle out_valid=0, out_data=0; after release, round-robin restarts at channel 0.
- Parameter sweep:
  - Stimulus: N=2, SELW=1, WIDTH=16; both valid; mode=1.
  - Required: grants alternate 0, 1, 0, 1; sel_err never set in mode 1.
